// File: rtl/synfull_delivery_buffer_pkg.sv
// Shared SynFull/ProNoC types and helpers for the delivery return path.
package synfull_delivery_buffer_pkg;

    // Ceiling log2 with a floor of 1, so a 2-entry queue still gets a 1-bit pointer.
    function automatic int log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Packet-size field width for each NoC configuration.
    function automatic int noc_pck_sizw(input int noc_id);
        case (noc_id)
            0:       return 4;
            default: return 6;
        endcase
    endfunction

    // Endpoint-address width for each NoC configuration.
    function automatic int noc_eaw(input int noc_id);
        case (noc_id)
            0:       return 4;
            default: return 6;
        endcase
    endfunction

    localparam int SYNFULL_ID_W = 32;
    localparam int DEF_PCK_SIZW = noc_pck_sizw(0);
    localparam int DEF_EAW      = noc_eaw(0);

    // One queued delivery as seen by the SynFull model in the default NoC configuration.
    typedef struct packed {
        logic [SYNFULL_ID_W-1:0] id;
        logic [DEF_PCK_SIZW-1:0] size;
        logic [DEF_EAW-1:0]      src;
    } synfull_del_entry_t;

    typedef struct packed {
        logic                    valid;
        logic [SYNFULL_ID_W-1:0] id;
    } deliver_t;

    typedef struct packed {
        logic                    valid;
        logic [DEF_EAW-1:0]      dest;
        logic [DEF_PCK_SIZW-1:0] size;
        logic [SYNFULL_ID_W-1:0] id;
    } req_t;

endpackage

// File: rtl/synfull_del_fifo.sv
// First-word-fall-through queue: storage array, wrapping pointers and occupancy.
// Full/empty come from the occupancy counter, so pointers may wrap freely.
module synfull_del_fifo
    import synfull_delivery_buffer_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int PTR_W = log2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             push_taken,
    output logic             pop_taken,
    output logic [OCC_W-1:0] occupancy,
    output logic [OCC_W-1:0] occupancy_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    assign full       = (occupancy == OCC_W'(DEPTH));
    assign rd_valid   = (occupancy != '0);
    assign pop_taken  = pop & rd_valid;
    assign push_taken = push & (~full | pop_taken);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        occupancy_next = occupancy;
        case ({push_taken, pop_taken})
            2'b10:   occupancy_next = occupancy + OCC_W'(1);
            2'b01:   occupancy_next = occupancy - OCC_W'(1);
            default: occupancy_next = occupancy;
        endcase
    end

    // Pointer and occupancy state; reset empties the queue without touching storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_taken) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_taken)  rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occupancy_next;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_taken) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/synfull_delivery_buffer.sv
// Per-endpoint return path from the packet injector's delivery side to SynFull.
// Queues every delivered packet in order, hands them out with valid/ready and
// keeps drop/delivery statistics for the end-of-run report.
module synfull_delivery_buffer
    import synfull_delivery_buffer_pkg::*;
#(
    parameter  int NOC_ID   = 0,
    parameter  int DEPTH    = 16,
    parameter  int ID_W     = 32,
    parameter  int CNT_W    = 32,
    localparam int PCK_SIZW = noc_pck_sizw(NOC_ID),
    localparam int EAW      = noc_eaw(NOC_ID),
    localparam int OCC_W    = log2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_pck_wr,
    input  logic [ID_W-1:0]     rx_id,
    input  logic [PCK_SIZW-1:0] rx_size,
    input  logic [EAW-1:0]      rx_src,
    output logic                del_valid,
    output logic [ID_W-1:0]     del_id,
    output logic [PCK_SIZW-1:0] del_size,
    output logic [EAW-1:0]      del_src,
    input  logic                del_ready,
    output logic [OCC_W-1:0]    occupancy,
    output logic                empty,
    output logic                overflow,
    output logic [CNT_W-1:0]    delivered_cnt,
    output logic [CNT_W-1:0]    dropped_cnt,
    output logic [OCC_W-1:0]    max_occupancy
);

    // Same layout as synfull_del_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [PCK_SIZW-1:0] size;
        logic [EAW-1:0]      src;
    } del_entry_t;

    del_entry_t       wr_entry;
    del_entry_t       rd_entry;
    logic             push_taken;
    logic             pop_taken;
    logic             drop;
    logic [OCC_W-1:0] occupancy_next;

    assign wr_entry = '{id: rx_id, size: rx_size, src: rx_src};

    synfull_del_fifo #(
        .DEPTH ($bits(del_entry_t) > 0 ? DEPTH : DEPTH),
        .WIDTH ($bits(del_entry_t))
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (rx_pck_wr),
        .pop            (del_ready),
        .wr_data        (wr_entry),
        .rd_valid       (del_valid),
        .rd_data        (rd_entry),
        .push_taken     (push_taken),
        .pop_taken      (pop_taken),
        .occupancy      (occupancy),
        .occupancy_next (occupancy_next)
    );

    assign del_id   = rd_entry.id;
    assign del_size = rd_entry.size;
    assign del_src  = rd_entry.src;
    assign empty    = ~del_valid;
    assign drop     = rx_pck_wr & ~push_taken;

    // Saturating statistics, sticky overflow flag and occupancy high-water mark.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delivered_cnt <= '0;
            dropped_cnt   <= '0;
            overflow      <= 1'b0;
            max_occupancy <= '0;
        end else begin
            if (pop_taken && (delivered_cnt != '1)) delivered_cnt <= delivered_cnt + CNT_W'(1);
            if (drop && (dropped_cnt != '1))        dropped_cnt   <= dropped_cnt + CNT_W'(1);
            if (drop)                               overflow      <= 1'b1;
            if (occupancy_next > max_occupancy)     max_occupancy <= occupancy_next;
        end
    end

`ifdef SIMULATION
    // Report each packet lost to a full queue.
    always @(posedge clk) begin
        if (reset && drop) $display("[synfull_delivery_buffer] warning: packet dropped at %0t, rx_id=0x%0h", $time, rx_id);
    end
`endif

endmodule

// File: tb/tb_synfull_delivery_buffer.sv
// Scoreboard bench for synfull_delivery_buffer: every accepted push is queued
// as an expectation and compared against the head whenever it is popped.
module tb_synfull_delivery_buffer;
    import synfull_delivery_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int ID_W  = 32;
    localparam int CNT_W = 32;
    localparam int SW    = noc_pck_sizw(0);
    localparam int AW    = noc_eaw(0);
    localparam int OW    = log2(DEPTH) + 1;
    localparam int EW    = ID_W + SW + AW;

    logic             clk;
    logic             reset;
    logic             rx_pck_wr;
    logic [ID_W-1:0]  rx_id;
    logic [SW-1:0]    rx_size;
    logic [AW-1:0]    rx_src;
    logic             del_valid;
    logic [ID_W-1:0]  del_id;
    logic [SW-1:0]    del_size;
    logic [AW-1:0]    del_src;
    logic             del_ready;
    logic [OW-1:0]    occupancy;
    logic             empty;
    logic             overflow;
    logic [CNT_W-1:0] delivered_cnt;
    logic [CNT_W-1:0] dropped_cnt;
    logic [OW-1:0]    max_occupancy;

    synfull_delivery_buffer #(
        .NOC_ID (0),
        .DEPTH  (DEPTH),
        .ID_W   (ID_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_pck_wr     (rx_pck_wr),
        .rx_id         (rx_id),
        .rx_size       (rx_size),
        .rx_src        (rx_src),
        .del_valid     (del_valid),
        .del_id        (del_id),
        .del_size      (del_size),
        .del_src       (del_src),
        .del_ready     (del_ready),
        .occupancy     (occupancy),
        .empty         (empty),
        .overflow      (overflow),
        .delivered_cnt (delivered_cnt),
        .dropped_cnt   (dropped_cnt),
        .max_occupancy (max_occupancy)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] expQ[$];
    int            expDelivered;
    int            expDropped;
    int            expMax;
    logic          expOverflow;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        expDelivered = 0;
        expDropped   = 0;
        expMax       = 0;
        expOverflow  = 1'b0;
    endtask

    // One clock cycle: check the head against the scoreboard, drive inputs, update the model.
    task automatic applyStimulus(input logic push, input logic [ID_W-1:0] id, input logic [SW-1:0] size,
                                 input logic [AW-1:0] src, input logic ready);
        logic doPop;
        logic wasFull;
        @(negedge clk);
        checkOutput("del_valid", 64'(del_valid), 64'(expQ.size() != 0));
        if (expQ.size() != 0) checkOutput("del_head", 64'({del_id, del_size, del_src}), 64'(expQ[0]));
        else                  checkOutput("del_zero", 64'({del_id, del_size, del_src}), 64'd0);
        checkOutput("occupancy", 64'(occupancy), 64'(expQ.size()));
        rx_pck_wr = push;
        rx_id     = id;
        rx_size   = size;
        rx_src    = src;
        del_ready = ready;
        doPop   = ready && (expQ.size() != 0);
        wasFull = (expQ.size() == DEPTH);
        if (doPop) begin
            void'(expQ.pop_front());
            expDelivered++;
        end
        if (push) begin
            if (!wasFull || doPop) expQ.push_back({id, size, src});
            else begin
                expDropped++;
                expOverflow = 1'b1;
            end
        end
        if (expQ.size() > expMax) expMax = expQ.size();
        @(posedge clk);
        #1;
        rx_pck_wr = 1'b0;
        del_ready = 1'b0;
    endtask

    task automatic checkStats(input string tag);
        @(negedge clk);
        checkOutput({tag, "_occupancy"}, 64'(occupancy), 64'(expQ.size()));
        checkOutput({tag, "_empty"}, 64'(empty), 64'(expQ.size() == 0));
        checkOutput({tag, "_delivered"}, 64'(delivered_cnt), 64'(expDelivered));
        checkOutput({tag, "_dropped"}, 64'(dropped_cnt), 64'(expDropped));
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'(expOverflow));
        checkOutput({tag, "_max_occ"}, 64'(max_occupancy), 64'(expMax));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    endtask

    initial begin
        int pushed;
        int startDelivered;
        reset     = 1'b0;
        rx_pck_wr = 1'b0;
        rx_id     = '0;
        rx_size   = '0;
        rx_src    = '0;
        del_ready = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        checkStats("reset");
        checkOutput("reset_del_valid", 64'(del_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single packet: visible one cycle after the push, popped on the next edge.
        $display("[TB] single packet");
        applyStimulus(1'b1, 32'hA5, 4'd4, 4'd3, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkStats("single");
        checkOutput("single_delivered_const", 64'(delivered_cnt), 64'd1);

        // Back-pressure: head holds while ready is low, then drains in order.
        $display("[TB] back-pressure");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 32'(i), SW'(i), AW'(i + 5), 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkOutput("bp_head_id", 64'(del_id), 64'd1);
        drain(3);
        checkStats("bp");

        // Overflow: 18 pushes into 16 entries with no reader.
        $display("[TB] overflow");
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 32'(100 + i), SW'(i), AW'(15 - (i % 16)), 1'b0);
        checkStats("ovf");
        checkOutput("ovf_occupancy_const", 64'(occupancy), 64'd16);
        checkOutput("ovf_dropped_const", 64'(dropped_cnt), 64'd2);
        checkOutput("ovf_max_const", 64'(max_occupancy), 64'd16);
        drain(16);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkStats("ovf_drain");

        // Full queue with simultaneous push and pop: nothing is dropped.
        $display("[TB] full push+pop");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(200 + i), SW'(i + 1), AW'(i), 1'b0);
        applyStimulus(1'b1, 32'd300, 4'd9, 4'd7, 1'b1);
        checkStats("fullpp");
        drain(16);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkStats("fullpp_drain");

        // Wrap-around with random back-pressure.
        $display("[TB] wrap-around");
        pushed = 0;
        startDelivered = expDelivered;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic doPush;
            if ((pushed == 40) && (expQ.size() == 0)) break;
            doPush = (pushed < 40) && (expQ.size() < DEPTH - 1) && ($urandom_range(0, 3) != 0);
            applyStimulus(doPush, 32'(1000 + pushed), SW'($urandom_range(0, 15)),
                          AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if (doPush) pushed++;
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkStats("wrap");
        checkOutput("wrap_delivered_delta", 64'(delivered_cnt), 64'(startDelivered + 40));

        // Reset in the middle of operation with 5 entries queued.
        $display("[TB] mid-run reset");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'(500 + i), SW'(i), AW'(i), 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        resetModel();
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_del_valid", 64'(del_valid), 64'd0);
        checkOutput("rst_empty", 64'(empty), 64'd1);
        checkOutput("rst_delivered", 64'(delivered_cnt), 64'd0);
        checkOutput("rst_dropped", 64'(dropped_cnt), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_max_occ", 64'(max_occupancy), 64'd0);
        checkOutput("rst_del_id", 64'(del_id), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h77, 4'd2, 4'd1, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkStats("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
